// File: rtl/eth_tx_pkt_arbiter.sv
// eth_tx_pkt_arbiter: round-robin packet arbiter of AXI-S requesters onto one TX port through a 2-entry skid buffer
module eth_tx_pkt_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_WIDTH = 64,
  parameter int CLIENT_WIDTH = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              s_tvalid,
  output logic [NUM_REQ-1:0]              s_tready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   s_tdata,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0] s_tkeep,
  input  logic [NUM_REQ-1:0]              s_tlast,
  input  logic [NUM_REQ-1:0]              s_tuser_error,
  output logic                            m_tvalid,
  input  logic                            m_tready,
  output logic [DATA_WIDTH-1:0]           m_tdata,
  output logic [DATA_WIDTH/8-1:0]         m_tkeep,
  output logic                            m_tlast,
  output logic [CLIENT_WIDTH-1:0]         m_tuser_client,
  output logic                            m_tuser_error,
  input  logic                            pause_xoff,
  output logic [CLIENT_WIDTH-1:0]         grant_id,
  output logic                            busy,
  output logic [NUM_REQ*16-1:0]           pkt_cnt
);
  localparam int KW = DATA_WIDTH / 8;
  localparam int EW = DATA_WIDTH + KW + CLIENT_WIDTH + 2;
  typedef enum logic {IDLE, LOCK} state_t;
  state_t state;
  logic [CLIENT_WIDTH-1:0] rr_ptr, pick;
  logic [1:0] cnt;
  logic [EW-1:0] ent [2];
  logic [EW-1:0] beat;
  logic [15:0] pkt_cnt_q [NUM_REQ];
  logic any, acc, pop, last_acc;
  int best, off;
  always_comb begin
    pick = '0;
    best = NUM_REQ;
    off = 0;
    for (int j = 0; j < NUM_REQ; j++) begin
      off = (j + NUM_REQ - int'(rr_ptr)) % NUM_REQ;
      if (s_tvalid[j] && off < best) begin
        best = off;
        pick = CLIENT_WIDTH'(j);
      end
    end
  end
  always_comb begin
    beat = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant_id == CLIENT_WIDTH'(i))
        beat = {s_tuser_error[i], s_tlast[i], s_tkeep[i*KW +: KW], s_tdata[i*DATA_WIDTH +: DATA_WIDTH], grant_id};
  end
  // ready depends only on registered state, so no combinational path from m_tready
  always_comb begin
    s_tready = '0;
    for (int i = 0; i < NUM_REQ; i++)
      s_tready[i] = state == LOCK && grant_id == CLIENT_WIDTH'(i) && cnt != 2'd2;
  end
  assign any = |s_tvalid;
  assign acc = |(s_tvalid & s_tready);
  assign last_acc = acc && beat[EW-2];
  assign pop = m_tvalid && m_tready;
  assign m_tvalid = cnt != 2'd0;
  assign {m_tuser_error, m_tlast, m_tkeep, m_tdata, m_tuser_client} = ent[0];
  assign busy = state == LOCK;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      rr_ptr <= '0;
      grant_id <= '0;
    end else if (state == IDLE) begin
      if (!pause_xoff && any) begin
        state <= LOCK;
        grant_id <= pick;
        rr_ptr <= pick == CLIENT_WIDTH'(NUM_REQ-1) ? '0 : pick + 1'b1;
      end
    end else if (last_acc) state <= IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      ent[0] <= '0;
      ent[1] <= '0;
    end else begin
      cnt <= cnt + 2'(acc) - 2'(pop);
      if (pop && cnt == 2'd2) ent[0] <= ent[1];
      else if (acc && (cnt == 2'd0 || pop)) ent[0] <= beat;
      if (acc && cnt == 2'd1 && !pop) ent[1] <= beat;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < NUM_REQ; i++) pkt_cnt_q[i] <= '0;
    else for (int i = 0; i < NUM_REQ; i++)
      if (last_acc && grant_id == CLIENT_WIDTH'(i)) pkt_cnt_q[i] <= pkt_cnt_q[i] + 16'd1;
  for (genvar i = 0; i < NUM_REQ; i++) assign pkt_cnt[i*16 +: 16] = pkt_cnt_q[i];
endmodule
